ps2_scan_ctrl: RTL

- Controller and sequencer placed after the PS/2 byte receiver. It runs in the system clock domain.
- Synchronises the receiver's valid strobe and captures each received byte.
- Decodes scan-code set 2 prefix sequences (E0 = extended, F0 = break) into single key events.
- Buffers the key events in a FIFO with a valid/ready handshake toward the consumer, e.g. a CPU register file or a text console.
- Also filters keyboard status bytes and recovers from half-finished prefix sequences with a watchdog.

---
 rtl/ps2_scan_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: synchronises the receiver strobe, folds E0/F0 prefixes
// into single key events, filters status bytes and buffers events in a show-ahead FIFO.
module ps2_scan_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_release,
    output logic       status_valid,
    output logic [7:0] status_code,
    output logic       overflow,
    output logic       seq_err,
    input  logic       clear
);
    localparam int                AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]       DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFC) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    logic             r_s1, r_s2, r_s3, r_stb;
    logic [7:0]       r_byte;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic [9:0]       r_mem [FIFO_DEPTH];

    logic             w_edge, w_push, w_err, w_status, w_pop, w_full, w_wr, w_drop;
    logic [9:0]       w_ev, w_head;
    state_t           w_next;

    // Registering the strobe with its byte gives the byte one clean decode cycle
    assign w_edge = r_s2 & ~r_s3;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_stb  <= 1'b0;
            r_byte <= 8'h00;
        end else begin
            r_s1  <= rx_valid;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_stb <= w_edge;
            if (w_edge)
                r_byte <= rx_data;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_push   = 1'b0;
        w_ev     = 10'd0;
        w_err    = 1'b0;
        w_status = 1'b0;
        if (r_stb) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte == 8'hE0)      w_next = S_EXT;
                    else if (r_byte == 8'hF0) w_next = S_BRK;
                    else if (is_status(r_byte)) w_status = 1'b1;
                    else begin
                        w_push = 1'b1;
                        w_ev   = {2'b00, r_byte};
                    end
                end
                S_EXT: begin
                    if (r_byte == 8'hF0) w_next = S_EXT_BRK;
                    else begin
                        w_next = S_IDLE;
                        if (r_byte == 8'hE0) w_err = 1'b1;
                        else begin
                            w_push = 1'b1;
                            w_ev   = {2'b01, r_byte};
                        end
                    end
                end
                default: begin
                    w_next = S_IDLE;
                    if (r_byte == 8'hE0 || r_byte == 8'hF0) w_err = 1'b1;
                    else begin
                        w_push = 1'b1;
                        w_ev   = {1'b1, (r_state == S_EXT_BRK), r_byte};
                    end
                end
            endcase
        end else if (r_state != S_IDLE && r_cnt == TO_LAST) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            status_valid <= 1'b0;
            status_code  <= 8'h00;
            seq_err      <= 1'b0;
        end else begin
            r_state      <= w_next;
            status_valid <= w_status;
            seq_err      <= w_err;
            if (w_status)
                status_code <= r_byte;
            if (r_stb || r_state == S_IDLE || w_err)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // A simultaneous pop frees the slot the push needs
    assign w_pop  = ev_valid & ev_ready;
    assign w_full = (r_count == DEPTH_C);
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)     overflow <= 1'b1;
            else if (clear) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= w_ev;
    end

    assign w_head     = r_mem[r_rptr];
    assign ev_valid   = (r_count != '0);
    assign ev_code    = ev_valid ? w_head[7:0] : 8'h00;
    assign ev_ext     = ev_valid & w_head[8];
    assign ev_release = ev_valid & w_head[9];
endmodule
